// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: major opcodes, canonical NOP and the
// decode-entry buffer state encoding ({skid_v, main_v}).
package riscv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Bit 1 is skid_v, bit 0 is main_v; 2'b10 can never occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } id_state_t;

endpackage

// File: rtl/riscv_rs_use_dec.sv
// Decodes which source-register fields an opcode actually reads, so that
// hazard detection ignores immediate bits that happen to alias rs1/rs2.
module riscv_rs_use_dec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       use_rs1,
  output logic       use_rs2
);

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP, STORE, BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, LOAD, JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_id_ctrl.sv
// Decode-stage entry controller: two-entry skid buffer between fetch and
// decode, load-use stall generation, flush handling and a stall counter.
module riscv_id_ctrl
  import riscv_pkg::*;
#(
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int PC_WIDTH        = 64,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [IBUS_DATA_WIDTH-1:0] if_instr,
  input  logic [PC_WIDTH-1:0]        if_pc,
  input  logic                       flush,
  input  logic                       ex_is_load,
  input  logic [4:0]                 ex_rd,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [IBUS_DATA_WIDTH-1:0] id_instr,
  output logic [PC_WIDTH-1:0]        id_pc,
  output logic [CNT_WIDTH-1:0]       stall_cnt
);

  id_state_t state_q, state_d;

  logic                       main_v, skid_v;
  logic [IBUS_DATA_WIDTH-1:0] main_instr, skid_instr;
  logic [PC_WIDTH-1:0]        main_pc, skid_pc;
  logic                       load_main_in, load_main_skid, load_skid;
  logic                       accept_in, fire_out;
  logic                       use_rs1, use_rs2, haz;
  logic [4:0]                 rs1, rs2;
  logic [CNT_WIDTH-1:0]       cnt_q;

  assign main_v = state_q[0];
  assign skid_v = state_q[1];

  // Ready depends only on registered state, breaking any id_ready -> if_ready path.
  assign if_ready  = ~skid_v;
  assign accept_in = if_valid & if_ready;
  assign fire_out  = id_valid & id_ready;

  assign rs1 = main_instr[19:15];
  assign rs2 = main_instr[24:20];

  riscv_rs_use_dec u_rs_use_dec (
    .opcode  (main_instr[6:0]),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign haz = main_v & ex_is_load & (ex_rd != 5'd0) &
               ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));

  assign id_valid  = main_v & ~haz;
  assign id_instr  = main_instr;
  assign id_pc     = main_pc;
  assign stall_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_in) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (fire_out && accept_in) begin
            load_main_in = 1'b1;
          end else if (fire_out) begin
            state_d = EMPTY;
          end else if (accept_in) begin
            load_skid = 1'b1;
            state_d   = TWO;
          end
        end
        TWO: begin
          if (fire_out) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main slot keeps its last contents while empty so id_instr stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_instr <= IBUS_DATA_WIDTH'(NOP);
      main_pc    <= '0;
    end else if (load_main_in) begin
      main_instr <= if_instr;
      main_pc    <= if_pc;
    end else if (load_main_skid) begin
      main_instr <= skid_instr;
      main_pc    <= skid_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_instr <= if_instr;
      skid_pc    <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (haz && !flush && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_riscv_id_ctrl.sv
// Self-checking bench for riscv_id_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based model of the decode-entry buffer.
module tb_riscv_id_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [63:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  logic [95:0] mq[$];
  int          m_cnt = 0;
  logic [31:0] m_instr = 32'h0000_0013;
  logic [63:0] m_pc = '0;

  localparam logic [31:0] ADD_X5 = 32'h007302B3;
  localparam logic [31:0] LUI_X5 = 32'h000302B7;

  riscv_id_ctrl #(.IBUS_DATA_WIDTH(32), .PC_WIDTH(64), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Hazard as stated by the ISA rules: which fields an opcode reads.
  function automatic bit m_haz();
    logic [31:0] ins;
    logic [6:0]  opc;
    bit          u1, u2;
    if (mq.size() == 0) return 1'b0;
    ins = mq[0][95:64];
    opc = ins[6:0];
    u1 = (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h03) ||
         (opc == 7'h23) || (opc == 7'h63) || (opc == 7'h67);
    u2 = (opc == 7'h33) || (opc == 7'h23) || (opc == 7'h63);
    return ex_is_load && (ex_rd != 0) &&
           ((u1 && ins[19:15] == ex_rd) || (u2 && ins[24:20] == ex_rd));
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && !m_haz();
  endfunction

  function automatic bit m_ready();
    return mq.size() < 2;
  endfunction

  task automatic set_in(input bit iv, input logic [31:0] ins, input logic [63:0] pc,
                        input bit fl, input bit ld, input logic [4:0] rd, input bit rdy);
    if_valid   = iv;
    if_instr   = ins;
    if_pc      = pc;
    flush      = fl;
    ex_is_load = ld;
    ex_rd      = rd;
    id_ready   = rdy;
    #1;
  endtask

  task automatic tick();
    bit h, fire, acc;
    h    = m_haz();
    fire = m_valid() && id_ready;
    acc  = if_valid && m_ready();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt   = 0;
      m_instr = 32'h0000_0013;
      m_pc    = '0;
    end else begin
      if (h && !flush && m_cnt != 15) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (fire) void'(mq.pop_front());
        if (acc) mq.push_back({if_instr, if_pc});
      end
      if (mq.size() > 0) begin
        m_instr = mq[0][95:64];
        m_pc    = mq[0][63:0];
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, '0, '0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready: got %b expected 1", if_ready); end
    if (id_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_id_instr: got %h expected 00000013", id_instr); end
    if (id_pc !== 64'd0) begin failures++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_streaming();
    logic [31:0] ins;
    logic [63:0] pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ins = 32'h0000_0013 | (32'(i + 1) << 20);
      pc  = 64'h100 + 64'(4 * i);
      set_in(1, ins, pc, 0, 0, 0, 1);
      checks++;
      if (if_ready !== 1'b1) begin failures++; $display("FAIL stream_if_ready[%0d]: got %b expected 1", i, if_ready); end
      tick();
      checks += 3;
      if (id_instr !== ins) begin failures++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, id_instr, ins); end
      if (id_pc !== pc) begin failures++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, id_pc, pc); end
      if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, id_valid); end
    end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(1, 32'h00100093, 64'h100, 0, 0, 0, 0);
    tick();
    checks += 2;
    if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_stall1: got %b expected 1", if_ready); end
    if (id_pc !== 64'h100) begin failures++; $display("FAIL bp_pc_stall1: got %h expected 100", id_pc); end
    set_in(1, 32'h00200113, 64'h104, 0, 0, 0, 0);
    tick();
    checks++;
    if (if_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_stall2: got %b expected 0", if_ready); end
    set_in(1, 32'h00300193, 64'h108, 0, 0, 0, 0);
    tick();
    checks += 3;
    if (if_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_stall3: got %b expected 0", if_ready); end
    if (id_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_stall3: got %b expected 1", id_valid); end
    if (id_pc !== 64'h100) begin failures++; $display("FAIL bp_pc_stall3: got %h expected 100", id_pc); end
    set_in(0, '0, '0, 0, 0, 0, 1);
    tick();
    checks += 3;
    if (id_pc !== 64'h104) begin failures++; $display("FAIL bp_release_pc: got %h expected 104", id_pc); end
    if (id_instr !== 32'h00200113) begin failures++; $display("FAIL bp_release_instr: got %h expected 00200113", id_instr); end
    if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", if_ready); end
    tick();
    checks += 2;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid: got %b expected 0", id_valid); end
    if (id_pc !== 64'h104) begin failures++; $display("FAIL bp_drain_pc: got %h expected 104", id_pc); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, ADD_X5, 64'h200, 0, 0, 0, 0);
    tick();
    set_in(0, '0, '0, 0, 1, 5'd6, 1);
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL lu_rs1_valid: got %b expected 0", id_valid); end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
    set_in(0, '0, '0, 0, 0, 5'd6, 0);
    checks += 2;
    if (id_valid !== 1'b1) begin failures++; $display("FAIL lu_after_valid: got %b expected 1", id_valid); end
    if (id_instr !== ADD_X5) begin failures++; $display("FAIL lu_after_instr: got %h expected %h", id_instr, ADD_X5); end
    set_in(0, '0, '0, 0, 1, 5'd0, 0);
    checks++;
    if (id_valid !== 1'b1) begin failures++; $display("FAIL lu_x0_valid: got %b expected 1", id_valid); end
    set_in(0, '0, '0, 0, 1, 5'd7, 0);
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL lu_rs2_valid: got %b expected 0", id_valid); end
    set_in(1, LUI_X5, 64'h204, 0, 0, 0, 1);
    tick();
    set_in(0, '0, '0, 0, 1, 5'd6, 0);
    checks += 2;
    if (id_valid !== 1'b1) begin failures++; $display("FAIL lu_lui_valid: got %b expected 1", id_valid); end
    if (id_instr !== LUI_X5) begin failures++; $display("FAIL lu_lui_instr: got %h expected %h", id_instr, LUI_X5); end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_lui_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 32'h00100093, 64'h300, 0, 0, 0, 0);
    tick();
    set_in(1, 32'h00200113, 64'h304, 0, 0, 0, 0);
    tick();
    set_in(1, 32'hDEAD0013, 64'h308, 1, 0, 0, 0);
    tick();
    checks += 2;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL flush2_valid: got %b expected 0", id_valid); end
    if (if_ready !== 1'b1) begin failures++; $display("FAIL flush2_ready: got %b expected 1", if_ready); end
    set_in(0, '0, '0, 0, 0, 0, 1);
    tick();
    tick();
    checks += 2;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL flush2_later_valid: got %b expected 0", id_valid); end
    if (id_instr === 32'hDEAD0013) begin failures++; $display("FAIL flush2_dropped: got %h expected not DEAD0013", id_instr); end
    set_in(1, 32'h00400213, 64'h400, 0, 0, 0, 0);
    tick();
    set_in(1, 32'hBEEF0013, 64'h404, 1, 0, 0, 0);
    checks++;
    if (if_ready !== 1'b1) begin failures++; $display("FAIL flush1_ready: got %b expected 1", if_ready); end
    tick();
    checks += 3;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL flush1_valid: got %b expected 0", id_valid); end
    if (id_pc !== 64'h400) begin failures++; $display("FAIL flush1_pc: got %h expected 400", id_pc); end
    if (id_instr !== 32'h00400213) begin failures++; $display("FAIL flush1_instr: got %h expected 00400213", id_instr); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    do_reset();
    set_in(1, ADD_X5, 64'h500, 0, 0, 0, 0);
    tick();
    set_in(0, '0, '0, 0, 1, 5'd6, 1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i > 15) ? 4'hF : 4'(i);
      checks++;
      if (stall_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt[%0d]: got %h expected %h", i, stall_cnt, exp_cnt); end
    end
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL sat_valid: got %b expected 0", id_valid); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    set_in(1, ADD_X5, 64'h600, 0, 0, 0, 0);
    tick();
    set_in(1, 32'h00500293, 64'h604, 0, 1, 5'd6, 0);
    tick();
    checks += 2;
    if (if_ready !== 1'b0) begin failures++; $display("FAIL rmid_pre_ready: got %b expected 0", if_ready); end
    if (stall_cnt !== 4'd1) begin failures++; $display("FAIL rmid_pre_cnt: got %0d expected 1", stall_cnt); end
    rst = 1'b1;
    set_in(1, 32'h00600313, 64'h608, 0, 0, 0, 1);
    tick();
    rst = 1'b0;
    set_in(0, '0, '0, 0, 0, 0, 1);
    checks += 5;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", id_valid); end
    if (if_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b expected 1", if_ready); end
    if (id_instr !== 32'h0000_0013) begin failures++; $display("FAIL rmid_instr: got %h expected 00000013", id_instr); end
    if (id_pc !== 64'd0) begin failures++; $display("FAIL rmid_pc: got %h expected 0", id_pc); end
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL rmid_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_random();
    logic [6:0]  opcs[10];
    logic [31:0] ins;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h7F};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ins        = $urandom;
      ins[6:0]   = opcs[$urandom_range(0, 9)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 99) < 2);
      set_in($urandom_range(0, 99) < 70, ins, 64'($urandom) << 2,
             $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 40,
             5'($urandom_range(0, 7)), $urandom_range(0, 99) < 65);
      checks += 5;
      if (if_ready !== m_ready()) begin failures++; $display("FAIL rand_if_ready[%0d]: got %b expected %b", i, if_ready, m_ready()); end
      if (id_valid !== m_valid()) begin failures++; $display("FAIL rand_id_valid[%0d]: got %b expected %b", i, id_valid, m_valid()); end
      if (id_instr !== m_instr) begin failures++; $display("FAIL rand_id_instr[%0d]: got %h expected %h", i, id_instr, m_instr); end
      if (id_pc !== m_pc) begin failures++; $display("FAIL rand_id_pc[%0d]: got %h expected %h", i, id_pc, m_pc); end
      if (stall_cnt !== 4'(m_cnt)) begin failures++; $display("FAIL rand_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, m_cnt); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_load_use();
    test_flush();
    test_saturation();
    test_reset_mid_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
